// File: rtl/sram_fifo_pkg.sv
// Shared types and width helpers for the SRAM-backed FWFT FIFO.
// Imported by the memory wrapper and the FIFO top.
package sram_fifo_pkg;

    typedef logic [1:0] occ_t;

    function automatic int fifo_aw(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 2;
    endfunction

endpackage

// File: rtl/fifo_sram_1w1r.sv
// Behavioural 1W1R SRAM, active-low chip enables, registered read port.
// Drop-in stand-in for the vendor macro.
module fifo_sram_1w1r
    import sram_fifo_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       cena,
    input  logic [fifo_aw(DEPTH)-1:0]  aa,
    output logic [WIDTH-1:0]           qa,
    input  logic                       cenb,
    input  logic [fifo_aw(DEPTH)-1:0]  ab,
    input  logic [WIDTH-1:0]           db
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!cenb) mem[ab] <= db;
        if (!cena) qa <= mem[aa];
    end

endmodule

// File: rtl/sram_fifo_fwft.sv
// First-word-fall-through FIFO over a 1W1R SRAM with a 2-entry output stage.
// Define SRAM_FIFO_ALMOST_EN to add registered almost_full/almost_empty.
module sram_fifo_fwft
    import sram_fifo_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 256
`ifdef SRAM_FIFO_ALMOST_EN
    ,
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int AEMPTY_TH = 4
`endif
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     wr_rdy,
    output logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_data,
    input  logic                     rd_rdy,
    output logic [cnt_w(DEPTH)-1:0]  count
`ifdef SRAM_FIFO_ALMOST_EN
    ,
    output logic                     almost_full,
    output logic                     almost_empty
`endif
);

    localparam int AW = fifo_aw(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [AW:0] MEM_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      mem_cnt;
    logic             inflight;
    occ_t             occ;
    occ_t             occ_nxt;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] skid;
    logic [WIDTH-1:0] sram_q;
    logic [CW-1:0]    count_nxt;
    logic             push;
    logic             pop;
    logic             issue;
    logic             cena;
    logic             cenb;

    assign wr_rdy  = (mem_cnt != MEM_FULL);
    assign rd_vld  = (occ != 2'd0);
    assign rd_data = head;
    assign push    = wr_vld && wr_rdy;
    assign pop     = rd_vld && rd_rdy;
    // Only prefetch when the word is guaranteed a slot on arrival.
    assign issue   = (mem_cnt != '0) &&
                     (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
    assign cena    = !issue;
    assign cenb    = !push;

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        occ_nxt = occ;
        if (inflight && !pop)
            occ_nxt = occ + 2'd1;
        else if (!inflight && pop)
            occ_nxt = occ - 2'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
            occ      <= 2'd0;
            head     <= '0;
            skid     <= '0;
            count    <= '0;
        end else if (clr) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
            occ      <= 2'd0;
            head     <= '0;
            skid     <= '0;
            count    <= '0;
        end else begin
            count    <= count_nxt;
            inflight <= issue;
            occ      <= occ_nxt;
            if (push) wptr <= wptr + AW'(1);
            if (issue) rptr <= rptr + AW'(1);
            unique case ({push, issue})
                2'b10:   mem_cnt <= mem_cnt + (AW+1)'(1);
                2'b01:   mem_cnt <= mem_cnt - (AW+1)'(1);
                default: mem_cnt <= mem_cnt;
            endcase
            // Arriving SRAM data goes to the first free slot after the pop.
            if (pop) begin
                if (occ == 2'd2) begin
                    head <= skid;
                    if (inflight) skid <= sram_q;
                end else if (inflight) begin
                    head <= sram_q;
                end
            end else if (inflight) begin
                if (occ == 2'd0) head <= sram_q;
                else skid <= sram_q;
            end
        end
    end

`ifdef SRAM_FIFO_ALMOST_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else if (clr) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (int'(count_nxt) >= AFULL_TH);
            almost_empty <= (int'(count_nxt) <= AEMPTY_TH);
        end
    end
`endif

    fifo_sram_1w1r #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_sram (
        .clk  (clk),
        .cena (cena),
        .aa   (rptr),
        .qa   (sram_q),
        .cenb (cenb),
        .ab   (wptr),
        .db   (wr_data)
    );

endmodule

// File: tb/tb_sram_fifo_fwft.sv
// Bench for sram_fifo_fwft: queue model checked every cycle plus directed
// literal checks (latency, full/drop, streaming, clr, reset, almost flags).
module tb_sram_fifo_fwft;

    localparam int WIDTH = 96;
    localparam int DEPTH = 256;
    localparam int CAP   = DEPTH + 2;

    logic             clk = 1'b0;
    logic             rstn;
    logic             clr;
    logic             wr_vld;
    logic [WIDTH-1:0] wr_data;
    logic             wr_rdy;
    logic             rd_vld;
    logic [WIDTH-1:0] rd_data;
    logic             rd_rdy;
    logic [9:0]       count;
`ifdef SRAM_FIFO_ALMOST_EN
    logic             almost_full;
    logic             almost_empty;
`endif

    always #5 clk = ~clk;

    sram_fifo_fwft #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (clr),
        .wr_vld  (wr_vld),
        .wr_data (wr_data),
        .wr_rdy  (wr_rdy),
        .rd_vld  (rd_vld),
        .rd_data (rd_data),
        .rd_rdy  (rd_rdy),
        .count   (count)
`ifdef SRAM_FIFO_ALMOST_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    // Model: word list with the edge index at which each was accepted.
    logic [WIDTH-1:0] mq[$];
    int               mt[$];
    int               t = 0;
    bit               m_pv;
    bit               m_pr;

    function automatic logic m_vld();
        return (mq.size() > 0) && (mt[0] <= t - 2);
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            mt.delete();
        end else begin
            m_pv = m_vld();
            m_pr = mq.size() < CAP;
            t++;
            if (clr) begin
                mq.delete();
                mt.delete();
            end else begin
                if (m_pv && rd_rdy) begin
                    void'(mq.pop_front());
                    void'(mt.pop_front());
                end
                if (wr_vld && m_pr) begin
                    mq.push_back(wr_data);
                    mt.push_back(t);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && mon_en) begin
            chk("m_count", count, mq.size());
            chk("m_wr_rdy", wr_rdy, mq.size() < CAP);
            chk("m_rd_vld", rd_vld, m_vld());
            if (m_vld()) chk("m_rd_data", rd_data, mq[0]);
`ifdef SRAM_FIFO_ALMOST_EN
            chk("m_afull", almost_full, mq.size() >= DEPTH - 4);
            chk("m_aempty", almost_empty, mq.size() <= 4);
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drain(input string name);
        rd_rdy = 1'b1;
        wr_vld = 1'b0;
        for (int c = 0; c < CAP + 20 && count != 0; c++) step();
        chk(name, count, 0);
        rd_rdy = 1'b0;
    endtask

    initial begin
        int n;
        rstn = 1'b0;
        clr = 1'b0;
        wr_vld = 1'b0;
        rd_rdy = 1'b0;
        wr_data = '0;
        #1;
        chk("rst_rd_vld", rd_vld, 0);
        chk("rst_wr_rdy", wr_rdy, 1);
        chk("rst_count", count, 0);
        chk("rst_rd_data", rd_data, 0);
`ifdef SRAM_FIFO_ALMOST_EN
        chk("rst_afull", almost_full, 0);
        chk("rst_aempty", almost_empty, 1);
`endif
        step();
        step();
        rstn = 1'b1;
        mon_en = 1'b1;

        // latency: push at edge 1, visible after edge 3
        wr_vld = 1'b1;
        wr_data = 'hA5;
        step();
        wr_vld = 1'b0;
        chk("lat_count_e1", count, 1);
        chk("lat_vld_e1", rd_vld, 0);
        step();
        chk("lat_vld_e2", rd_vld, 0);
        step();
        chk("lat_vld_e3", rd_vld, 1);
        chk("lat_data_e3", rd_data, 'hA5);
        chk("lat_count_e3", count, 1);
        rd_rdy = 1'b1;
        step();
        rd_rdy = 1'b0;
        chk("lat_pop_count", count, 0);

        // fill to capacity, one extra push is dropped
        for (int i = 0; i < CAP; i++) begin
            wr_vld = 1'b1;
            wr_data = WIDTH'(i);
            step();
        end
        chk("full_wr_rdy", wr_rdy, 0);
        chk("full_count", count, CAP);
        wr_data = 'd999;
        step();
        wr_vld = 1'b0;
        chk("drop_count", count, CAP);
        rd_rdy = 1'b1;
        n = 0;
        for (int c = 0; c < CAP + 20 && n < CAP; c++) begin
            if (rd_vld) begin
                chk("drain_seq", rd_data, n);
                n++;
            end
            step();
        end
        chk("drain_n", n, CAP);
        step();
        step();
        chk("drop_absent", rd_vld, 0);
        chk("drain_count", count, 0);

        // streaming push+pop every cycle across pointer wrap
        rd_rdy = 1'b1;
        wr_vld = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            wr_data = WIDTH'(1000 + i);
            step();
            if (i >= 2) begin
                chk("stream_vld", rd_vld, 1);
                chk("stream_count", count, 3);
            end
        end
        drain("stream_drain");

        // random traffic with back-pressure
        for (int i = 0; i < 400; i++) begin
            wr_vld = 1'($urandom_range(0, 1));
            rd_rdy = 1'($urandom_range(0, 1));
            wr_data = {$urandom, $urandom, $urandom};
            step();
        end
        drain("rand_drain");

        // clr with push and pop in the same cycle, read in flight
        for (int i = 0; i < 10; i++) begin
            wr_vld = 1'b1;
            wr_data = WIDTH'('h500 + i);
            step();
        end
        wr_vld = 1'b0;
        step();
        step();
        step();
        chk("clr_pre_count", count, 10);
        rd_rdy = 1'b1;
        step();
        clr = 1'b1;
        wr_vld = 1'b1;
        wr_data = 'hDEAD;
        step();
        clr = 1'b0;
        wr_vld = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_vld", rd_vld, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("clr_no_stale", rd_vld, 0);
        end
        rd_rdy = 1'b0;
        wr_vld = 1'b1;
        wr_data = 'h77;
        step();
        wr_vld = 1'b0;
        step();
        step();
        chk("clr_new_vld", rd_vld, 1);
        chk("clr_new_data", rd_data, 'h77);
        drain("clr_drain");

`ifdef SRAM_FIFO_ALMOST_EN
        for (int i = 0; i < DEPTH - 5; i++) begin
            wr_vld = 1'b1;
            wr_data = WIDTH'(i);
            step();
        end
        wr_vld = 1'b0;
        step();
        chk("af_251_count", count, 251);
        chk("af_251", almost_full, 0);
        wr_vld = 1'b1;
        step();
        wr_vld = 1'b0;
        chk("af_252_count", count, 252);
        chk("af_252", almost_full, 1);
        rd_rdy = 1'b1;
        for (int c = 0; c < CAP && count > 5; c++) step();
        rd_rdy = 1'b0;
        chk("ae_5_count", count, 5);
        chk("ae_5", almost_empty, 0);
        rd_rdy = 1'b1;
        step();
        rd_rdy = 1'b0;
        chk("ae_4_count", count, 4);
        chk("ae_4", almost_empty, 1);
        drain("almost_drain");
`endif

        // asynchronous reset in the middle of traffic
        wr_vld = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_data = WIDTH'('h900 + i);
            rd_rdy = 1'($urandom_range(0, 1));
            step();
        end
        rd_rdy = 1'b0;
        step();
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_vld", rd_vld, 0);
        chk("mid_rst_wr_rdy", wr_rdy, 1);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_data", rd_data, 0);
`ifdef SRAM_FIFO_ALMOST_EN
        chk("mid_rst_afull", almost_full, 0);
        chk("mid_rst_aempty", almost_empty, 1);
`endif
        wr_vld = 1'b0;
        step();
        rstn = 1'b1;
        wr_vld = 1'b1;
        wr_data = 'h3C;
        step();
        wr_vld = 1'b0;
        chk("post_rst_count", count, 1);
        step();
        step();
        chk("post_rst_vld", rd_vld, 1);
        chk("post_rst_data", rd_data, 'h3C);
        drain("final_drain");

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
